actuator_periph_master: RTL and testbench
=========================================

ACTUATOR_PERIPH_MASTER -- requirements
Module: actuator_periph_master

Interface
REQ-001 Parameter N_REGS, default 4, number of job-dependent 32-bit config words per job (1..16).
REQ-002 Parameter ID, default 10, width of periph_id_o / periph_r_id_i.
REQ-003 Parameter TAG, default 1, constant ID value driven on periph_id_o.
REQ-004 Parameter BASE_ADDR, default 32'h0000_0000, byte base of the target HWPE register file.
REQ-005 Parameter MAX_RETRY, default 16, maximum busy ACQUIRE responses before abort.
REQ-006 clk_i  in  1  single clock; all logic on rising edge.
REQ-007 rst_i  in  1  asynchronous, active-high reset.
REQ-008 start_i  in  1  job launch request, sampled only in IDLE.
REQ-009 cfg_i  in  N_REGS x 32  config words, latched on accepted start_i.
REQ-010 evt_i  in  1  HWPE end-of-job event, single-cycle pulse.
REQ-011 busy_o  out  1  high from accepted start until DONE/abort.
REQ-012 done_o  out  1  one-cycle pulse on job completion.
REQ-013 err_o  out  1  one-cycle pulse on acquire abort.
REQ-014 job_id_o  out  8  job ID returned by ACQUIRE; held until next acquire.
REQ-015 periph_req_o / periph_gnt_i  out/in  1 / 1  request/grant.
REQ-016 periph_add_o  out  32; periph_wen_o  out  1 (1 = read, 0 = write); periph_be_o  out  4; periph_data_o  out  32; periph_id_o  out  ID.
REQ-017 periph_r_data_i  in  32; periph_r_valid_i  in  1; periph_r_id_i  in  ID.

Function
REQ-018 FSM states: IDLE, ACQ_REQ, ACQ_RSP, CFG_REQ, CFG_RSP, TRG_REQ, TRG_RSP, WAIT_EVT.
REQ-019 IDLE: start_i=1 latches cfg_i, clears retry and index counters, sets busy_o, goes to ACQ_REQ next cycle.
REQ-020 ACQ_REQ: read (wen=1, be=4'hF) at BASE_ADDR+0x04; on gnt -> ACQ_RSP.
REQ-021 ACQ_RSP: on matching r_valid, r_data[31]=1 means busy: retry counter increments; if counter reaches MAX_RETRY -> IDLE with err_o pulse, else -> ACQ_REQ.
REQ-022 ACQ_RSP: matching r_valid with r_data[31]=0 loads job_id_o = r_data[7:0] -> CFG_REQ with index k=0.
REQ-023 CFG_REQ: write (wen=0, be=4'hF) cfg word k to BASE_ADDR+0x40+4*k; on gnt -> CFG_RSP.
REQ-024 CFG_RSP: on matching r_valid, k=N_REGS-1 -> TRG_REQ, else k+1 -> CFG_REQ.
REQ-025 TRG_REQ: write 32'h0 to BASE_ADDR+0x00; on gnt -> TRG_RSP; matching r_valid -> WAIT_EVT.
REQ-026 WAIT_EVT: evt_i=1 -> IDLE, done_o pulses same cycle as transition, busy_o drops.
REQ-027 evt_i outside WAIT_EVT is ignored (not latched).
REQ-028 periph_req_o high only in *_REQ states; add/wen/be/data stable while req high and gnt low.
REQ-029 At most one outstanding transaction; no new req before matching r_valid.
REQ-030 r_valid accepted as matching only when periph_r_id_i == TAG; other r_valid ignored.
REQ-031 r_valid arriving in the same cycle as gnt is not accepted; response valid earliest the cycle after gnt.
REQ-032 Minimum latency per transaction: req cycle + 1 response cycle; zero-wait ACQUIRE-to-WAIT_EVT = 2*(N_REGS+2) cycles.
REQ-033 start_i while busy_o=1 is ignored.
REQ-034 Outputs outside active states: periph_add_o, periph_data_o = 0, periph_wen_o=1, periph_be_o=0, periph_id_o=TAG.

Reset
REQ-035 rst_i asserted at any time (including mid-transaction) forces IDLE immediately; no further req.
REQ-036 Reset values: periph_req_o=0, busy_o=0, done_o=0, err_o=0, job_id_o=0, counters 0, latched cfg 0.
REQ-037 Responses arriving after reset release while in IDLE are ignored.

Verification
REQ-038 N_REGS=4, zero-wait slave, ACQUIRE returns 0x00000003 -> writes 0x40,0x44,0x48,0x4C with cfg_i, write 0 to 0x00, job_id_o=3, done_o one cycle after evt_i.
REQ-039 ACQUIRE returns 0xFFFFFFFF twice then 0x00000005 -> exactly 3 ACQUIRE reads, job_id_o=5, job completes.
REQ-040 MAX_RETRY=16, ACQUIRE always 0xFFFFFFFF -> 16 reads, err_o pulse, busy_o=0, no config writes.
REQ-041 gnt delayed 3 cycles on each request -> req/add/data held stable all 3 cycles; r_valid with wrong r_id ignored.
REQ-042 rst_i pulsed during CFG_RSP of word 2 -> all outputs at reset values, FSM IDLE; new start_i runs a full job from ACQUIRE.
REQ-043 evt_i pulsed during CFG_REQ and start_i during WAIT_EVT -> both ignored; done_o only after evt_i in WAIT_EVT.

Source files
------------

// File: rtl/actuator_periph_master.sv
// rtl/actuator_periph_master.sv - HWPE job launcher: acquire, program config words, trigger, await end-of-job event
module actuator_periph_master #(
  parameter int          N_REGS    = 4,
  parameter int          ID        = 10,
  parameter int          TAG       = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_RETRY = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [N_REGS-1:0][31:0] cfg_i,
  input  logic                   evt_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [7:0]             job_id_o,
  output logic                   periph_req_o,
  input  logic                   periph_gnt_i,
  output logic [31:0]            periph_add_o,
  output logic                   periph_wen_o,
  output logic [3:0]             periph_be_o,
  output logic [31:0]            periph_data_o,
  output logic [ID-1:0]          periph_id_o,
  input  logic [31:0]            periph_r_data_i,
  input  logic                   periph_r_valid_i,
  input  logic [ID-1:0]          periph_r_id_i
);
  localparam int KW = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [ID-1:0] TAG_ID = ID'(TAG);
  localparam logic [KW-1:0] K_LAST = KW'(N_REGS - 1);
  localparam logic [RW-1:0] R_LAST = RW'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    IDLE, ACQ_REQ, ACQ_RSP, CFG_REQ, CFG_RSP, TRG_REQ, TRG_RSP, WAIT_EVT
  } state_t;

  state_t                  state_q, state_d;
  logic [N_REGS-1:0][31:0] cfg_q;
  logic [KW-1:0]           k_q;
  logic [RW-1:0]           retry_q;
  logic [7:0]              job_id_q;
  logic                    done_q, err_q;
  logic                    rsp_ok;
  logic                    start_acc, acq_busy, acq_ok, cfg_next, job_done, abort;
  logic                    unused_rdata;

  // Responses only count in *_RSP states, so an r_valid coincident with gnt is never taken.
  assign rsp_ok       = periph_r_valid_i && (periph_r_id_i == TAG_ID);
  assign unused_rdata = ^periph_r_data_i[30:8];

  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign job_id_o    = job_id_q;
  assign periph_id_o = TAG_ID;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    start_acc     = 1'b0;
    acq_busy      = 1'b0;
    acq_ok        = 1'b0;
    cfg_next      = 1'b0;
    job_done      = 1'b0;
    abort         = 1'b0;
    periph_req_o  = 1'b0;
    periph_add_o  = 32'h0;
    periph_wen_o  = 1'b1;
    periph_be_o   = 4'h0;
    periph_data_o = 32'h0;
    case (state_q)
      IDLE: if (start_i) begin
        start_acc = 1'b1;
        state_d   = ACQ_REQ;
      end
      ACQ_REQ: begin
        periph_req_o = 1'b1;
        periph_add_o = BASE_ADDR + 32'h04;
        periph_be_o  = 4'hF;
        if (periph_gnt_i) state_d = ACQ_RSP;
      end
      ACQ_RSP: if (rsp_ok) begin
        // Bit 31 set means the accelerator is still owned by another job.
        if (periph_r_data_i[31]) begin
          if (retry_q == R_LAST) begin
            abort   = 1'b1;
            state_d = IDLE;
          end else begin
            acq_busy = 1'b1;
            state_d  = ACQ_REQ;
          end
        end else begin
          acq_ok  = 1'b1;
          state_d = CFG_REQ;
        end
      end
      CFG_REQ: begin
        periph_req_o  = 1'b1;
        periph_add_o  = BASE_ADDR + 32'h40 + 32'({k_q, 2'b00});
        periph_wen_o  = 1'b0;
        periph_be_o   = 4'hF;
        periph_data_o = cfg_q[k_q];
        if (periph_gnt_i) state_d = CFG_RSP;
      end
      CFG_RSP: if (rsp_ok) begin
        if (k_q == K_LAST) state_d = TRG_REQ;
        else begin
          cfg_next = 1'b1;
          state_d  = CFG_REQ;
        end
      end
      TRG_REQ: begin
        periph_req_o = 1'b1;
        periph_add_o = BASE_ADDR;
        periph_wen_o = 1'b0;
        periph_be_o  = 4'hF;
        if (periph_gnt_i) state_d = TRG_RSP;
      end
      TRG_RSP:  if (rsp_ok) state_d = WAIT_EVT;
      WAIT_EVT: if (evt_i) begin
        job_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_q    <= '0;
      k_q      <= '0;
      retry_q  <= '0;
      job_id_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= job_done;
      err_q  <= abort;
      if (start_acc) begin
        cfg_q   <= cfg_i;
        k_q     <= '0;
        retry_q <= '0;
      end
      if (acq_busy) retry_q <= retry_q + RW'(1);
      if (acq_ok) begin
        job_id_q <= periph_r_data_i[7:0];
        k_q      <= '0;
      end
      if (cfg_next) k_q <= k_q + KW'(1);
    end
  end
endmodule

// File: tb/tb_actuator_periph_master.sv
// tb/tb_actuator_periph_master.sv - directed self-checking bench for actuator_periph_master
module tb_actuator_periph_master;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [3:0][31:0]  cfg = '0;
  logic              evt = 1'b0;
  logic              busy, done, err;
  logic [7:0]        job_id;
  logic              req, gnt = 1'b0;
  logic [31:0]       add;
  logic              wen;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [9:0]        pid;
  logic [31:0]       rdata = '0;
  logic              rvalid = 1'b0;
  logic [9:0]        rid = '0;
  int                total = 0;
  int                bad = 0;
  int                cyc = 0;
  int                c0 = 0;

  actuator_periph_master dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .cfg_i(cfg), .evt_i(evt),
    .busy_o(busy), .done_o(done), .err_o(err), .job_id_o(job_id),
    .periph_req_o(req), .periph_gnt_i(gnt), .periph_add_o(add), .periph_wen_o(wen),
    .periph_be_o(be), .periph_data_o(wdata), .periph_id_o(pid),
    .periph_r_data_i(rdata), .periph_r_valid_i(rvalid), .periph_r_id_i(rid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic serve(input int dly, input logic [31:0] rd, input logic [31:0] eadd,
                       input logic ewen, input logic [31:0] edata, input bit noisy);
    int t = 0;
    while (!req && t < 50) begin @(negedge clk); t++; end
    chk("req_seen", 32'(t < 50), 32'd1);
    chk("add", add, eadd);
    chk("wen", 32'(wen), 32'(ewen));
    chk("be", 32'(be), 32'hF);
    chk("pid", 32'(pid), 32'd1);
    if (!ewen) chk("wdata", wdata, edata);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("hold_req", 32'(req), 32'd1);
      chk("hold_add", add, eadd);
      chk("hold_data", wdata, ewen ? wdata : edata);
    end
    gnt = 1'b1;
    if (noisy) begin rvalid = 1'b1; rid = 10'd1; rdata = rd; end
    @(negedge clk);
    gnt = 1'b0;
    if (noisy) begin
      rid = 10'd2;
      @(negedge clk);
      chk("no_req_pending", 32'(req), 32'd0);
    end
    rvalid = 1'b1; rid = 10'd1; rdata = rd;
    @(negedge clk);
    rvalid = 1'b0; rdata = '0;
  endtask

  task automatic run_job(input logic [3:0][31:0] c, input logic [7:0] jid, input int nbusy,
                         input int dly, input bit noisy, input bit disturb);
    cfg = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cfg = '0;
    chk("busy_on", 32'(busy), 32'd1);
    c0 = cyc;
    for (int i = 0; i < nbusy; i++) serve(dly, 32'hFFFF_FFFF, 32'h04, 1'b1, 32'h0, noisy);
    serve(dly, {24'h0, jid}, 32'h04, 1'b1, 32'h0, noisy);
    chk("job_id", 32'(job_id), {24'h0, jid});
    if (disturb) begin
      evt = 1'b1;
      @(negedge clk);
      evt = 1'b0;
      chk("evt_in_cfg_busy", 32'(busy), 32'd1);
      chk("evt_in_cfg_done", 32'(done), 32'd0);
    end
    for (int k = 0; k < 4; k++) serve(dly, 32'h0, 32'h40 + 32'(4 * k), 1'b0, c[k], noisy);
    serve(dly, 32'h0, 32'h00, 1'b0, 32'h0, noisy);
    if (dly == 0 && nbusy == 0 && !noisy && !disturb) chk("latency", 32'(cyc - c0), 32'd12);
    chk("wait_req", 32'(req), 32'd0);
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_done", 32'(done), 32'd0);
    if (disturb) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("start_in_wait_req", 32'(req), 32'd0);
      chk("start_in_wait_done", 32'(done), 32'd0);
      chk("start_in_wait_busy", 32'(busy), 32'd1);
    end
    evt = 1'b1;
    @(negedge clk);
    evt = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_off", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_cleared", 32'(done), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(req), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_jobid"}, 32'(job_id), 32'd0);
    chk({tag, "_add"}, add, 32'h0);
    chk({tag, "_wen"}, 32'(wen), 32'd1);
    chk({tag, "_be"}, 32'(be), 32'd0);
    chk({tag, "_data"}, wdata, 32'h0);
    chk({tag, "_pid"}, 32'(pid), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req", 32'(req), 32'd0);

    run_job({32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001}, 8'h03, 0, 0, 1'b0, 1'b0);
    run_job({32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 8'h05, 2, 0, 1'b0, 1'b1);
    run_job({32'hCAFE_0003, 32'hBEEF_0002, 32'h1234_5678, 32'h8765_4321}, 8'h07, 0, 3, 1'b1, 1'b0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 16; i++) serve(0, 32'hFFFF_FFFF, 32'h04, 1'b1, 32'h0, 1'b0);
    chk("abort_err", 32'(err), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_req", 32'(req), 32'd0);
    chk("abort_jobid_held", 32'(job_id), 32'd7);
    @(negedge clk);
    chk("abort_err_clr", 32'(err), 32'd0);
    chk("abort_no_cfg_write", 32'(req), 32'd0);

    cfg = {32'h0D, 32'h0C, 32'h0B, 32'h0A};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    serve(0, 32'h0000_0009, 32'h04, 1'b1, 32'h0, 1'b0);
    serve(0, 32'h0, 32'h40, 1'b0, 32'h0A, 1'b0);
    serve(0, 32'h0, 32'h44, 1'b0, 32'h0B, 1'b0);
    chk("w2_add", add, 32'h48);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    rvalid = 1'b1; rid = 10'd1; rdata = 32'h0000_0011;
    @(negedge clk);
    rvalid = 1'b0; rdata = '0;
    chk("stray_rsp_busy", 32'(busy), 32'd0);
    chk("stray_rsp_req", 32'(req), 32'd0);
    chk("stray_rsp_jobid", 32'(job_id), 32'd0);
    run_job({32'h0000_0044, 32'h0000_0033, 32'h0000_0022, 32'h0000_0011}, 8'h2A, 0, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
